// File: rtl/data_fifo_pkg.sv
// data_fifo_pkg: elaboration helpers shared by the parametrised data FIFO.
// Holds the pointer-width calculation and the parameter sanity checks;
// per-instance pointer types live in the top, where their width is known.
package data_fifo_pkg;

  // Index width for a DEPTH-entry storage array (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // True when v is a power of two no smaller than 2.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Threshold ranges: almost_full in 1..DEPTH, almost_empty in 0..DEPTH-1.
  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/data_fifo_ram.sv
// data_fifo_ram: DEPTH x WIDTH FIFO storage.
// One synchronous write port, one asynchronous read port; contents are
// deliberately not reset so the array maps onto plain register/LUT RAM.
module data_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write accepted words into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/data_fifo_param.sv
// data_fifo_param: parametrised single-clock first-word-fall-through FIFO.
// Pointers carry one extra wrap bit, so count is a plain modular difference
// and full/empty need no extra state. All flags and dout derive from the
// pointer registers only; wr_en/rd_en never reach them combinationally.
// Optional macro DATA_FIFO_ERR_EN adds sticky overflow/underflow flags;
// without it both outputs are tied low and no flops are spent on them.
module data_fifo_param
  import data_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

  // Reject illegal configurations while elaborating.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("data_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("data_fifo_param: AF_THRESH/AE_THRESH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("data_fifo_param: WIDTH must be >= 1");
  end

  logic [ADDR_W:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty, w_full;
  logic              w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0]  w_ram_rd;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                   (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

  // A write into a full FIFO is fine when a read frees the head slot in the
  // same cycle; a read on empty is ignored even if a write arrives (no bypass).
  // Flush overrides both, and also blocks the storage write.
  assign w_wr_acc = wr_en & (~w_full | rd_en) & ~flush;
  assign w_rd_acc = rd_en & ~w_empty & ~flush;

  // Pointer update: async reset, flush clears, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  data_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .raddr (r_rd_ptr[ADDR_W-1:0]),
    .rdata (w_ram_rd)
  );

  // Storage is never reset, so mask the head word while empty.
  assign dout         = w_empty ? '0 : w_ram_rd;
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_T);
  assign almost_empty = (w_count <= AE_T);

`ifdef DATA_FIFO_ERR_EN
  logic r_overflow, r_underflow;

  // Sticky error capture; cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Refused write: full with no simultaneous read.
      if (wr_en & w_full & ~rd_en) r_overflow <= 1'b1;
      // Read on empty is only an error when no write arrives alongside it.
      if (rd_en & w_empty & ~wr_en) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_fifo_param.sv
// tb_data_fifo_param: self-checking bench for data_fifo_param
// (WIDTH=8, DEPTH=16, AF_THRESH=12, AE_THRESH=2). A queue-based reference
// model tracks contents and sticky flags; a constant vector table and
// directed corner sequences run first, then a randomized phase.
module tb_data_fifo_param;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  bit m_ovf = 0, m_unf = 0;
`ifdef DATA_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  data_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: FIFO as a queue, rules applied with the pre-edge contents.
  task automatic model_apply(input bit fl, input bit wr, input bit rd, input logic [7:0] d);
    bit is_full, is_empty, wacc, racc;
    if (fl) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    is_full  = (mq.size() == DEPTH);
    is_empty = (mq.size() == 0);
    wacc = wr && (!is_full || rd);
    racc = rd && !is_empty;
    if (ERR_EN && wr && !wacc) m_ovf = 1;
    if (ERR_EN && rd && is_empty && !wr) m_unf = 1;
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(d);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, "/count"}, 32'(count), 32'(n));
    chk({tag, "/dout"},  32'(dout), (n > 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "/empty"}, 32'(empty), 32'(n == 0));
    chk({tag, "/full"},  32'(full), 32'(n == DEPTH));
    chk({tag, "/aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, "/afull"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, "/ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, "/unf"},   32'(underflow), 32'(m_unf));
  endtask

  // One clock: drive, take the edge, sample #1 later, update the model.
  task automatic step(input bit fl, input bit wr, input bit rd, input logic [7:0] d);
    flush = fl; wr_en = wr; rd_en = rd; din = d;
    @(posedge clk); #1;
    model_apply(fl, wr, rd, d);
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  typedef struct {
    bit fl, wr, rd;
    logic [7:0] d;
    int cnt;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Hand-derived expectations after each edge, starting from empty.
    tbl[0] = '{0,1,0,8'hA1, 1, 8'hA1};
    tbl[1] = '{0,1,0,8'hB2, 2, 8'hA1};
    tbl[2] = '{0,0,1,8'h00, 1, 8'hB2};
    tbl[3] = '{0,1,1,8'hC3, 1, 8'hC3};
    tbl[4] = '{0,0,1,8'h00, 0, 8'h00};
    tbl[5] = '{0,0,1,8'h00, 0, 8'h00};
    tbl[6] = '{0,1,1,8'hD4, 1, 8'hD4};
    tbl[7] = '{0,1,0,8'hE5, 2, 8'hD4};
    tbl[8] = '{1,1,1,8'h99, 0, 8'h00};
    tbl[9] = '{0,1,0,8'h5A, 1, 8'h5A};

    // Reset state.
    #3;
    chk("rst/count", 32'(count), 0);
    chk("rst/empty", 32'(empty), 1);
    chk("rst/full", 32'(full), 0);
    chk("rst/aempty", 32'(almost_empty), 1);
    chk("rst/afull", 32'(almost_full), 0);
    chk("rst/dout", 32'(dout), 0);
    chk("rst/ovf", 32'(overflow), 0);
    chk("rst/unf", 32'(underflow), 0);
    @(posedge clk); #1; rst = 1'b1;

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d/count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d/dout", i), 32'(dout), 32'(tbl[i].exp_dout));
      check_all($sformatf("tbl%0d", i));
    end

    // 1: async reset mid-stream with count=5.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(i + 8'h10));
    chk("t1/pre_count", 32'(count), 5);
    #2; rst = 1'b0; #1;
    mq.delete(); m_ovf = 0; m_unf = 0;
    chk("t1/count", 32'(count), 0);
    chk("t1/empty", 32'(empty), 1);
    chk("t1/dout", 32'(dout), 0);
    @(posedge clk); #1; rst = 1'b1;
    step(0, 1, 0, 8'hA5);
    chk("t1/dout_a5", 32'(dout), 32'hA5);
    check_all("t1");
    step(0, 0, 1, 0);

    // 2: fill 0x00..0x0F, watch almost_full and full edges.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(i));
      chk($sformatf("t2/count%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("t2/afull%0d", i), 32'(almost_full), 32'(i + 1 >= 12));
      chk($sformatf("t2/full%0d", i), 32'(full), 32'(i == 15));
    end
    check_all("t2");

    // 3: full, simultaneous read/write for 20 cycles (wrap crossed twice).
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t3/head%0d", k), 32'(dout), (k < 16) ? 32'(k) : 32'h77);
      step(0, 1, 1, 8'h77);
      chk($sformatf("t3/count%0d", k), 32'(count), 16);
      chk($sformatf("t3/ovf%0d", k), 32'(overflow), 0);
    end
    check_all("t3");
    // Drain; remaining order checked by the model.
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, 0);
      check_all($sformatf("t3d%0d", k));
    end

    // 4: empty, write+read together: write wins, no underflow.
    step(0, 1, 1, 8'h3C);
    chk("t4/count", 32'(count), 1);
    chk("t4/dout", 32'(dout), 32'h3C);
    chk("t4/unf", 32'(underflow), 0);

    // 5: count=9, flush beats write/read.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h40 + i));
    chk("t5/pre_count", 32'(count), 9);
    step(1, 1, 1, 8'hEE);
    chk("t5/count", 32'(count), 0);
    chk("t5/empty", 32'(empty), 1);
    chk("t5/aempty", 32'(almost_empty), 1);
    chk("t5/ovf", 32'(overflow), 0);
    chk("t5/unf", 32'(underflow), 0);

    // 6: refused write on full, refused read on empty.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(8'h80 + i));
    step(0, 1, 0, 8'hFF);
    chk("t6/ovf", 32'(overflow), 32'(ERR_EN));
    chk("t6/count", 32'(count), 16);
    step(0, 0, 0, 0);
    chk("t6/ovf_held", 32'(overflow), 32'(ERR_EN));
    check_all("t6a");
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t6/unf", 32'(underflow), 32'(ERR_EN));
    chk("t6/count_e", 32'(count), 0);
    check_all("t6b");

    // Randomized traffic in write-heavy, balanced and read-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      int wp;
      wp = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
      for (int n = 0; n < 600; n++) begin
        bit fl, wr, rd;
        fl = ($urandom_range(0, 149) == 0);
        wr = ($urandom_range(0, 99) < wp);
        rd = ($urandom_range(0, 99) < 100 - wp);
        step(fl, wr, rd, 8'($urandom));
        check_all($sformatf("rnd%0d_%0d", ph, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
